// File: rtl/veripg_pkg.sv
`default_nettype none
// veripg_pkg -- types shared across VeriPG blocks.
// Rev 1.0
package veripg_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3,
    S_ERR    = 3'd4
  } issuer_state_t;

endpackage
`default_nettype wire

// File: rtl/veripg_timeout_ctr.sv
`default_nettype none
// veripg_timeout_ctr -- clearable up-counter flagging its TIMEOUT-th enabled cycle.
// Rev 1.0
module veripg_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_LAST = c_TW'(TIMEOUT - 1);

  logic [c_TW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + c_TW'(1);
    end
  end

  // Expiry only counts while enabled so a stale count outside the wait window is harmless.
  assign o_expire = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/veripg_job_issuer.sv
`default_nettype none
// veripg_job_issuer -- runs a command as N back-to-back engine jobs with per-job timeout.
// Rev 1.0
module veripg_job_issuer
  import veripg_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_count,
  output logic             req_ready,
  output logic             eng_start,
  input  logic             eng_busy,
  input  logic             eng_done,
  input  logic             err_clear,
  output logic             cmd_done,
  output logic             active,
  output logic [WIDTH-1:0] jobs_done,
  output logic             err_timeout
);

  issuer_state_t    r_state;
  issuer_state_t    w_next_state;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] r_jobs_done;
  logic             w_accept;
  logic             w_done_in_wait;
  logic             w_timer_clear;
  logic             w_timer_enable;
  logic             w_expire;
  logic             w_unused;

  // Engine busy is observational only; completion is tracked purely from eng_done.
  assign w_unused = eng_busy;

  assign w_accept       = (r_state == S_IDLE) && req_valid;
  assign w_done_in_wait = (r_state == S_WAIT) && eng_done;
  assign w_timer_clear  = (r_state == S_ISSUE);
  assign w_timer_enable = (r_state == S_WAIT);

  veripg_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_enable),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next_state = (req_count != '0) ? S_ISSUE : S_FINISH;
        end
      end
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        // A completion on the expiry cycle still counts as a completion.
        if (eng_done) begin
          w_next_state = (r_remaining == WIDTH'(1)) ? S_FINISH : S_ISSUE;
        end else if (w_expire) begin
          w_next_state = S_ERR;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      S_ERR: begin
        if (err_clear) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
      r_jobs_done <= '0;
    end else if (w_accept) begin
      r_remaining <= req_count;
      r_jobs_done <= '0;
    end else if (w_done_in_wait) begin
      r_remaining <= r_remaining - WIDTH'(1);
      r_jobs_done <= r_jobs_done + WIDTH'(1);
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign eng_start   = (r_state == S_ISSUE);
  assign cmd_done    = (r_state == S_FINISH);
  assign active      = (r_state != S_IDLE);
  assign err_timeout = (r_state == S_ERR);
  assign jobs_done   = r_jobs_done;

endmodule
`default_nettype wire

// File: tb/tb_veripg_job_issuer.sv
`default_nettype none
// tb_veripg_job_issuer -- randomized command/engine stimulus against a job-level reference model.
// Rev 1.0
module tb_veripg_job_issuer;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [WIDTH-1:0] req_count;
  logic             req_ready;
  logic             eng_start;
  logic             eng_busy;
  logic             eng_done;
  logic             err_clear;
  logic             cmd_done;
  logic             active;
  logic [WIDTH-1:0] jobs_done;
  logic             err_timeout;

  int total = 0;
  int bad   = 0;
  int starts;
  int dones;
  int lat_tab [256];

  veripg_job_issuer #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_count   (req_count),
    .req_ready   (req_ready),
    .eng_start   (eng_start),
    .eng_busy    (eng_busy),
    .eng_done    (eng_done),
    .err_clear   (err_clear),
    .cmd_done    (cmd_done),
    .active      (active),
    .jobs_done   (jobs_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (eng_start) starts++;
    if (cmd_done)  dones++;
  endtask

  // Engine answers job j exactly lat_tab[j] cycles after its start pulse.
  task automatic run_cmd(input int n, input string tag,
                         output bit got_err, output int start_to_err, output int iters);
    int cnt;
    int j;
    int budget;
    budget = 0;
    while (!req_ready && budget < 50) begin
      tick();
      budget++;
    end
    chk({tag, "_ready"}, req_ready, 1);
    starts    = 0;
    dones     = 0;
    req_valid = 1'b1;
    req_count = n[WIDTH-1:0];
    tick();
    req_valid = 1'b0;
    cnt   = -1;
    j     = 0;
    iters = 0;
    while (!cmd_done && !err_timeout && iters < n * (TIMEOUT + 4) + 20) begin
      if (eng_start) cnt = 0;
      else if (cnt >= 0) cnt++;
      eng_done  = (cnt >= 0) && (cnt == lat_tab[j]);
      eng_busy  = (cnt >= 0) && !eng_done;
      err_clear = ($urandom_range(0, 3) == 0);
      if (eng_done) begin
        j++;
        cnt = -1;
      end
      tick();
      iters++;
    end
    eng_done  = 1'b0;
    eng_busy  = 1'b0;
    err_clear = 1'b0;
    chk({tag, "_finished"}, (cmd_done || err_timeout), 1);
    got_err      = err_timeout;
    start_to_err = cnt + 1;
  endtask

  // Reference: jobs complete in order until the first one slower than TIMEOUT.
  task automatic check_cmd(input int n, input string tag);
    bit got_err;
    int s2e;
    int iters;
    int k;
    int jobs_before;
    k = 0;
    while (k < n && lat_tab[k] <= TIMEOUT) k++;
    run_cmd(n, tag, got_err, s2e, iters);
    chk({tag, "_err"}, got_err, (k < n));
    chk({tag, "_jobs"}, jobs_done, k % 256);
    chk({tag, "_starts"}, starts, (k < n) ? k + 1 : n);
    chk({tag, "_cmd_done"}, dones, (k < n) ? 0 : 1);
    if (n == 0) chk({tag, "_zero_lat"}, iters, 0);
    if (got_err) begin
      chk({tag, "_err_lat"}, s2e, TIMEOUT + 1);
      jobs_before = jobs_done;
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      tick();
      tick();
      chk({tag, "_err_hold"}, err_timeout, 1);
      chk({tag, "_err_active"}, active, 1);
      chk({tag, "_err_stray"}, jobs_done, jobs_before);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk({tag, "_err_clr"}, err_timeout, 0);
      chk({tag, "_err_idle"}, req_ready, 1);
    end else begin
      tick();
      chk({tag, "_post_ready"}, req_ready, 1);
      chk({tag, "_post_pulse"}, cmd_done, 0);
      chk({tag, "_post_active"}, active, 0);
      chk({tag, "_post_jobs"}, jobs_done, k % 256);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk({tag, "_idle_stray"}, jobs_done, k % 256);
    end
  endtask

  task automatic reset_mid_cmd();
    int cnt;
    int budget;
    starts    = 0;
    dones     = 0;
    req_valid = 1'b1;
    req_count = 8'd4;
    tick();
    req_valid = 1'b0;
    cnt    = -1;
    budget = 0;
    while (starts < 2 && budget < 40) begin
      if (eng_start) cnt = 0;
      else if (cnt >= 0) cnt++;
      eng_done = (cnt == 3);
      if (eng_done) cnt = -1;
      tick();
      budget++;
    end
    eng_done = 1'b0;
    chk("rst_reach_job2", starts, 2);
    tick();
    rst = 1'b1;
    #2;
    chk("rst_async_start", eng_start, 0);
    chk("rst_async_done", cmd_done, 0);
    chk("rst_async_active", active, 0);
    chk("rst_async_err", err_timeout, 0);
    chk("rst_async_jobs", jobs_done, 0);
    tick();
    tick();
    rst = 1'b0;
    starts = 0;
    dones  = 0;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    tick();
    tick();
    chk("rst_stray_jobs", jobs_done, 0);
    chk("rst_no_cmd_done", dones, 0);
    chk("rst_no_start", starts, 0);
    chk("rst_ready", req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_count = '0;
    eng_busy  = 1'b0;
    eng_done  = 1'b0;
    err_clear = 1'b0;
    starts    = 0;
    dones     = 0;
    #1;
    chk("reset_active", active, 0);
    chk("reset_start", eng_start, 0);
    chk("reset_cmd_done", cmd_done, 0);
    chk("reset_err", err_timeout, 0);
    chk("reset_jobs", jobs_done, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_ready", req_ready, 1);

    for (int i = 0; i < 3; i++) lat_tab[i] = 2;
    check_cmd(3, "three_jobs");

    check_cmd(0, "zero_jobs");

    lat_tab[0] = NEVER;
    check_cmd(1, "no_answer");

    lat_tab[0] = TIMEOUT;
    lat_tab[1] = TIMEOUT;
    check_cmd(2, "done_at_edge");

    lat_tab[0] = 5;
    lat_tab[1] = TIMEOUT + 1;
    check_cmd(3, "late_second");

    for (int c = 0; c < 10; c++) begin
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) begin
        lat_tab[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT + 1, TIMEOUT + 4)
                                                 : $urandom_range(1, TIMEOUT);
      end
      check_cmd(n, $sformatf("rand%0d", c));
    end

    reset_mid_cmd();

    for (int i = 0; i < 255; i++) lat_tab[i] = $urandom_range(1, TIMEOUT);
    check_cmd(255, "max_count");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
